// File: rtl/rgb2ycbcr_stream.sv
`default_nettype none
// ============================================================================
// Module      : rgb2ycbcr_stream
// Description : Three-stage pipelined RGB to YCbCr (BT.601 full range)
//               converter with a valid/ready stream interface.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb2ycbcr_stream #(
    parameter int IN_W        = 8,
    parameter int OUT_W       = 32,
    parameter int LEVEL_SHIFT = 1,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_r,
    input  logic [IN_W-1:0]         in_g,
    input  logic [IN_W-1:0]         in_b,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_y,
    output logic signed [OUT_W-1:0] out_cb,
    output logic signed [OUT_W-1:0] out_cr,
    output logic                    out_last,
    output logic [CNT_W-1:0]        pix_cnt
);

    localparam int PROD_W = IN_W + 16;
    localparam logic signed [OUT_W-1:0] OFFSET = OUT_W'(1) << (IN_W + 15);
    // Coefficient magnitudes; the sign of each term is applied in the adder stage.
    localparam logic [15:0] COEF [9] = '{
        16'h4C8B, 16'h9645, 16'h1D2F,
        16'h2B32, 16'h54CD, 16'h8000,
        16'h8000, 16'h6B2F, 16'h14D0
    };

    if (OUT_W < IN_W + 18) begin : g_bad_out_w
        $error("rgb2ycbcr_stream: OUT_W must be at least IN_W+18");
    end

    logic                    en;
    logic                    acc;
    logic                    rdy_q;
    logic                    v1_q, v1_d;
    logic                    v2_q, v2_d;
    logic                    ov_q, ov_d;
    logic                    last1_q, last1_d;
    logic                    last2_q, last2_d;
    logic                    olast_q, olast_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PROD_W-1:0]       prod_q [9];
    logic [PROD_W-1:0]       prod_d [9];
    logic signed [OUT_W-1:0] ext    [9];
    logic signed [OUT_W-1:0] ysum_q, cbsum_q, crsum_q;
    logic signed [OUT_W-1:0] ysum_d, cbsum_d, crsum_d;
    logic signed [OUT_W-1:0] y_q, cb_q, cr_q;
    logic signed [OUT_W-1:0] y_d, cb_d, cr_d;

    assign en       = ~ov_q | out_ready;
    assign in_ready = en & rdy_q;
    assign acc      = in_valid & in_ready;

    for (genvar i = 0; i < 9; i++) begin : g_prod
        logic [IN_W-1:0] comp;
        assign comp      = (i % 3 == 0) ? in_r : ((i % 3 == 1) ? in_g : in_b);
        assign prod_d[i] = {16'b0, comp} * {{IN_W{1'b0}}, COEF[i]};
        assign ext[i]    = $signed({{(OUT_W-PROD_W){1'b0}}, prod_q[i]});
    end

    assign ysum_d  =  ext[0] + ext[1] + ext[2];
    assign cbsum_d = -ext[3] - ext[4] + ext[5];
    assign crsum_d =  ext[6] - ext[7] - ext[8];

    if (LEVEL_SHIFT != 0) begin : g_shift
        assign y_d  = ysum_q - OFFSET;
        assign cb_d = cbsum_q;
        assign cr_d = crsum_q;
    end else begin : g_noshift
        assign y_d  = ysum_q;
        assign cb_d = cbsum_q + OFFSET;
        assign cr_d = crsum_q + OFFSET;
    end

    // Control next-state: every stage advances together whenever en is high.
    always_comb begin
        v1_d    = en ? acc  : v1_q;
        v2_d    = en ? v1_q : v2_q;
        ov_d    = en ? v2_q : ov_q;
        last1_d = acc ? in_last : last1_q;
        last2_d = (en & v1_q) ? last1_q : last2_q;
        olast_d = en ? (v2_q & last2_q) : olast_q;
        cnt_d   = (ov_q & out_ready) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q   <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            ov_q    <= 1'b0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            olast_q <= 1'b0;
            cnt_q   <= '0;
            ysum_q  <= '0;
            cbsum_q <= '0;
            crsum_q <= '0;
            y_q     <= '0;
            cb_q    <= '0;
            cr_q    <= '0;
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            rdy_q   <= 1'b1;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            ov_q    <= ov_d;
            last1_q <= last1_d;
            last2_q <= last2_d;
            olast_q <= olast_d;
            cnt_q   <= cnt_d;
            // Data registers only load behind a valid item; bubbles leave them untouched.
            if (acc) begin
                for (int i = 0; i < 9; i++) begin
                    prod_q[i] <= prod_d[i];
                end
            end
            if (en & v1_q) begin
                ysum_q  <= ysum_d;
                cbsum_q <= cbsum_d;
                crsum_q <= crsum_d;
            end
            if (en & v2_q) begin
                y_q  <= y_d;
                cb_q <= cb_d;
                cr_q <= cr_d;
            end
        end
    end

    assign out_valid = ov_q;
    assign out_last  = olast_q;
    assign out_y     = y_q;
    assign out_cb    = cb_q;
    assign out_cr    = cr_q;
    assign pix_cnt   = cnt_q;

endmodule
`default_nettype wire
